// File: rtl/bib_bellek_arayuzu_if.sv
// Data-memory bus carrying one registered request (valid/ready) and its response.
// The interface block drives it as master; the memory model or RAM wrapper is the slave.
interface bib_bellek_arayuzu_if;
   logic        istek_gecerli;
   logic        istek_hazir;
   logic [31:0] adr;
   logic [31:0] veri;
   logic [3:0]  maske;
   logic        yaz;
   logic        yanit_gecerli;
   logic [31:0] yanit_veri;

   modport master (
      output istek_gecerli, adr, veri, maske, yaz,
      input  istek_hazir, yanit_gecerli, yanit_veri
   );

   modport slave (
      input  istek_gecerli, adr, veri, maske, yaz,
      output istek_hazir, yanit_gecerli, yanit_veri
   );
endinterface

// File: rtl/bib_bellek_arayuzu.sv
// Turns the memory unit's single-beat request into a registered valid/ready bus transaction and stalls the pipeline until it completes.
// Optional response timeout is enabled by defining BIB_ZAMAN_ASIMI_EN.
module bib_bellek_arayuzu #(
   parameter int unsigned ZAMAN_ASIMI     = 256,
   parameter int unsigned ZAMAN_SAYAC_BIT = 10,
   parameter logic [31:0] HATA_VERISI     = 32'h0000_0000
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        bib_sec_i,
   input  logic [31:0]                 bib_adr_i,
   input  logic [31:0]                 bib_veri_i,
   input  logic [3:0]                  bib_veri_maske_i,
   output logic [31:0]                 bib_veri_o,
   output logic                        bib_durdur_o,
   output logic                        hata_o,
   bib_bellek_arayuzu_if.master        bellek
);

   typedef enum logic [1:0] {
      BOSTA = 2'd0,
      ISTEK = 2'd1,
      YANIT = 2'd2
   } durum_t;

   durum_t      durum_q;
   logic        gecerli_q;
   logic        yaz_q;
   logic        hata_q;
   logic [31:0] adr_q;
   logic [31:0] veri_q;
   logic [3:0]  maske_q;
   logic [31:0] son_veri_q;
   logic [31:0] son_veri_d;

   logic        tamam;
   logic        zorla;
   logic        bitis;
   logic        beklenmedik;
   logic        el_sikisma;
   logic [31:0] donus_veri;

   assign tamam       = (durum_q == YANIT) && bellek.yanit_gecerli;
   assign beklenmedik = bellek.yanit_gecerli && (durum_q != YANIT);
   assign bitis       = tamam || zorla;
   assign el_sikisma  = gecerli_q && bellek.istek_hazir && !zorla;

`ifdef BIB_ZAMAN_ASIMI_EN
   localparam logic [ZAMAN_SAYAC_BIT-1:0] SAYAC_SON = ZAMAN_SAYAC_BIT'(ZAMAN_ASIMI - 1);

   logic [ZAMAN_SAYAC_BIT-1:0] sayac_q;

   // Held at zero while idle, so it starts from zero on every ISTEK entry.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sayac_q <= '0;
      end else if (durum_q == BOSTA) begin
         sayac_q <= '0;
      end else begin
         sayac_q <= sayac_q + 1'b1;
      end
   end

   assign zorla      = (durum_q != BOSTA) && (sayac_q == SAYAC_SON) && !tamam;
   assign donus_veri = zorla ? HATA_VERISI : (yaz_q ? 32'h0 : bellek.yanit_veri);
`else
   logic parametre_unused;
   assign parametre_unused = ^{HATA_VERISI, ZAMAN_ASIMI[0], ZAMAN_SAYAC_BIT[0]};
   assign zorla      = 1'b0;
   assign donus_veri = yaz_q ? 32'h0 : bellek.yanit_veri;
`endif

   assign son_veri_d = bitis ? donus_veri : son_veri_q;

   always_comb begin
      bib_veri_o   = son_veri_q;
      bib_durdur_o = 1'b0;
      if (durum_q == BOSTA) begin
         bib_durdur_o = bib_sec_i;
      end else begin
         bib_durdur_o = !bitis;
         if (bitis) begin
            bib_veri_o = donus_veri;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         durum_q    <= BOSTA;
         gecerli_q  <= 1'b0;
         adr_q      <= 32'h0;
         veri_q     <= 32'h0;
         maske_q    <= 4'h0;
         yaz_q      <= 1'b0;
         hata_q     <= 1'b0;
         son_veri_q <= 32'h0;
      end else begin
         hata_q     <= beklenmedik || zorla;
         son_veri_q <= son_veri_d;
         case (durum_q)
            BOSTA: begin
               if (bib_sec_i) begin
                  adr_q     <= bib_adr_i;
                  veri_q    <= bib_veri_i;
                  maske_q   <= bib_veri_maske_i;
                  yaz_q     <= |bib_veri_maske_i;
                  gecerli_q <= 1'b1;
                  durum_q   <= ISTEK;
               end
            end
            ISTEK: begin
               if (zorla) begin
                  gecerli_q <= 1'b0;
                  durum_q   <= BOSTA;
               end else if (el_sikisma) begin
                  gecerli_q <= 1'b0;
                  durum_q   <= YANIT;
               end
            end
            YANIT: begin
               if (bitis) begin
                  durum_q <= BOSTA;
               end
            end
            default: begin
               gecerli_q <= 1'b0;
               durum_q   <= BOSTA;
            end
         endcase
      end
   end

   // A forced completion withdraws a still-pending request in the same cycle.
   assign bellek.istek_gecerli = gecerli_q && !zorla;
   assign bellek.adr           = adr_q;
   assign bellek.veri          = veri_q;
   assign bellek.maske         = maske_q;
   assign bellek.yaz           = yaz_q;
   assign hata_o               = hata_q;

endmodule

// File: tb/tb_bib_bellek_arayuzu.sv
// Directed and randomized transactions against a transaction-level model of the memory interface block.
module tb_bib_bellek_arayuzu;
   localparam logic [31:0] HATA_V = 32'hDEAD_0BAD;

   logic        clk = 1'b0;
   logic        rst;
   logic        sec;
   logic [31:0] adr;
   logic [31:0] veri;
   logic [3:0]  maske;
   logic [31:0] bib_veri;
   logic        durdur;
   logic        hata;

   int karsilastirma = 0;
   int uyumsuz       = 0;
   logic [31:0] son_veri_m;

   bib_bellek_arayuzu_if bellek ();

   bib_bellek_arayuzu #(
      .ZAMAN_ASIMI(8),
      .ZAMAN_SAYAC_BIT(10),
      .HATA_VERISI(HATA_V)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bib_sec_i(sec),
      .bib_adr_i(adr),
      .bib_veri_i(veri),
      .bib_veri_maske_i(maske),
      .bib_veri_o(bib_veri),
      .bib_durdur_o(durdur),
      .hata_o(hata),
      .bellek(bellek)
   );

   always #5 clk = ~clk;

   task automatic kontrol(input string tag, input logic [31:0] g, input logic [31:0] b);
      karsilastirma++;
      assert (g === b) else begin
         uyumsuz++;
         $error("FAIL %s: observed %h expected %h", tag, g, b);
      end
   endtask

   task automatic sonraki();
      @(posedge clk);
      #1;
   endtask

   // One full transaction: dr cycles of ready held low, dy cycles of response delay.
   task automatic islem(input logic [31:0] a, input logic [31:0] v, input logic [3:0] m,
                        input int dr, input int dy, input logic [31:0] cevap, input bit tut);
      logic [31:0] bekl;
      bekl = (m == 4'h0) ? cevap : 32'h0;
      sec = 1'b1; adr = a; veri = v; maske = m;
      bellek.istek_hazir = 1'b0; bellek.yanit_gecerli = 1'b0; bellek.yanit_veri = $urandom;
      @(negedge clk);
      kontrol("c0_durdur", {31'h0, durdur}, 32'h1);
      kontrol("c0_gecerli", {31'h0, bellek.istek_gecerli}, 32'h0);
      sonraki();
      for (int i = 0; i <= dr; i++) begin
         sec = tut; adr = $urandom; veri = $urandom; maske = 4'($urandom);
         bellek.istek_hazir = (i == dr);
         bellek.yanit_veri  = $urandom;
         @(negedge clk);
         kontrol("istek_gecerli", {31'h0, bellek.istek_gecerli}, 32'h1);
         kontrol("istek_adr", bellek.adr, a);
         kontrol("istek_veri", bellek.veri, v);
         kontrol("istek_maske", {28'h0, bellek.maske}, {28'h0, m});
         kontrol("istek_yaz", {31'h0, bellek.yaz}, {31'h0, |m});
         kontrol("istek_durdur", {31'h0, durdur}, 32'h1);
         kontrol("istek_hata", {31'h0, hata}, 32'h0);
         sonraki();
      end
      for (int i = 0; i <= dy; i++) begin
         bellek.istek_hazir   = 1'($urandom);
         bellek.yanit_gecerli = (i == dy);
         bellek.yanit_veri    = (i == dy) ? cevap : $urandom;
         @(negedge clk);
         kontrol("yanit_gecerli0", {31'h0, bellek.istek_gecerli}, 32'h0);
         kontrol("yanit_durdur", {31'h0, durdur}, {31'h0, i != dy});
         kontrol("yanit_veri", bib_veri, (i == dy) ? bekl : son_veri_m);
         sonraki();
      end
      son_veri_m = bekl;
      sec = 1'b0; bellek.yanit_gecerli = 1'b0; bellek.istek_hazir = 1'b0;
      @(negedge clk);
      kontrol("son_durdur", {31'h0, durdur}, 32'h0);
      kontrol("son_veri", bib_veri, son_veri_m);
      kontrol("son_gecerli", {31'h0, bellek.istek_gecerli}, 32'h0);
      kontrol("son_hata", {31'h0, hata}, 32'h0);
      sonraki();
   endtask

   initial begin
      logic [31:0] ra;
      logic [3:0]  rm;
      rst = 1'b1; sec = 1'b0; adr = 32'h0; veri = 32'h0; maske = 4'h0;
      bellek.istek_hazir = 1'b0; bellek.yanit_gecerli = 1'b0; bellek.yanit_veri = 32'h0;
      son_veri_m = 32'h0;
      sonraki();
      sonraki();
      @(negedge clk);
      kontrol("rst_gecerli", {31'h0, bellek.istek_gecerli}, 32'h0);
      kontrol("rst_adr", bellek.adr, 32'h0);
      kontrol("rst_yaz", {31'h0, bellek.yaz}, 32'h0);
      kontrol("rst_hata", {31'h0, hata}, 32'h0);
      kontrol("rst_veri", bib_veri, 32'h0);
      kontrol("rst_durdur", {31'h0, durdur}, 32'h0);
      sonraki();
      rst = 1'b0;
      sonraki();

      // Minimum-latency load, then a store with ready held low for five cycles.
      islem(32'h0000_1000, 32'h1234_5678, 4'b0000, 0, 0, 32'hCAFE_BABE, 1'b0);
      islem(32'h0000_2004, 32'h00AB_0000, 4'b0100, 5, 0, 32'h5555_AAAA, 1'b0);
      // Select kept high past capture still yields one bus transaction.
      islem(32'h0000_3008, 32'h0, 4'b0000, 1, 2, 32'h0BAD_F00D, 1'b1);

      // Unexpected response while idle.
      bellek.yanit_gecerli = 1'b1; bellek.yanit_veri = 32'h1111_2222;
      sonraki();
      bellek.yanit_gecerli = 1'b0;
      @(negedge clk);
      kontrol("bosta_hata1", {31'h0, hata}, 32'h1);
      kontrol("bosta_veri", bib_veri, son_veri_m);
      kontrol("bosta_gecerli", {31'h0, bellek.istek_gecerli}, 32'h0);
      kontrol("bosta_durdur", {31'h0, durdur}, 32'h0);
      sonraki();
      @(negedge clk);
      kontrol("bosta_hata0", {31'h0, hata}, 32'h0);
      sonraki();
      islem(32'h0000_4000, 32'h0, 4'b0000, 0, 1, 32'h7777_0001, 1'b0);

      // Reset while waiting for a response.
      sec = 1'b1; adr = 32'h0000_5000; veri = 32'hFFFF_FFFF; maske = 4'b1111;
      sonraki();
      sec = 1'b0; bellek.istek_hazir = 1'b1;
      sonraki();
      bellek.istek_hazir = 1'b0; rst = 1'b1;
      @(negedge clk);
      kontrol("yanit_bekle_durdur", {31'h0, durdur}, 32'h1);
      sonraki();
      rst = 1'b0;
      son_veri_m = 32'h0;
      @(negedge clk);
      kontrol("rst2_gecerli", {31'h0, bellek.istek_gecerli}, 32'h0);
      kontrol("rst2_adr", bellek.adr, 32'h0);
      kontrol("rst2_veri", bellek.veri, 32'h0);
      kontrol("rst2_maske", {28'h0, bellek.maske}, 32'h0);
      kontrol("rst2_yaz", {31'h0, bellek.yaz}, 32'h0);
      kontrol("rst2_bibveri", bib_veri, 32'h0);
      kontrol("rst2_durdur", {31'h0, durdur}, 32'h0);
      sonraki();
      islem(32'h0000_6000, 32'h0, 4'b0000, 0, 0, 32'h8888_9999, 1'b0);

      for (int n = 0; n < 20; n++) begin
         ra = $urandom & 32'hFFFF_FFFC;
         rm = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
         islem(ra, $urandom, rm, $urandom_range(0, 2), $urandom_range(0, 2), $urandom,
               1'($urandom_range(0, 1)));
      end

`ifdef BIB_ZAMAN_ASIMI_EN
      // No response: forced completion in the eighth cycle after select.
      sec = 1'b1; adr = 32'h0000_7000; veri = 32'h0; maske = 4'h0;
      sonraki();
      for (int c = 1; c <= 8; c++) begin
         sec = 1'b0; bellek.istek_hazir = (c == 1);
         @(negedge clk);
         kontrol("za_durdur", {31'h0, durdur}, {31'h0, c < 8});
         if (c == 8) begin
            kontrol("za_veri", bib_veri, HATA_V);
            kontrol("za_gecerli", {31'h0, bellek.istek_gecerli}, 32'h0);
         end
         sonraki();
      end
      bellek.istek_hazir = 1'b0;
      son_veri_m = HATA_V;
      @(negedge clk);
      kontrol("za_hata1", {31'h0, hata}, 32'h1);
      kontrol("za_sonveri", bib_veri, HATA_V);
      sonraki();
      bellek.yanit_gecerli = 1'b1;
      @(negedge clk);
      kontrol("za_hata0", {31'h0, hata}, 32'h0);
      sonraki();
      bellek.yanit_gecerli = 1'b0;
      @(negedge clk);
      kontrol("za_gec_hata", {31'h0, hata}, 32'h1);
      sonraki();
      @(negedge clk);
      kontrol("za_gec_hata0", {31'h0, hata}, 32'h0);
      sonraki();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", karsilastirma, uyumsuz);
      $finish;
   end
endmodule
